// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending dispense stage: FSM states,
// coin denominations and the exact-change payability check.
package vend_pkg;

    localparam int unsigned DEFAULT_CHANGE_W = 4;
    localparam int unsigned COIN_SMALL       = 1;
    localparam int unsigned COIN_LARGE       = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DROP,
        ST_PAY,
        ST_WAIT_ACK,
        ST_CLEAR,
        ST_HOLD,
        ST_FAULT
    } state_t;

    // Greedy 5-coin count, limited by stock; the remainder must fit in 1-coins.
    function automatic logic payable(input int unsigned change,
                                     input int unsigned stock5,
                                     input int unsigned stock1);
        int unsigned n5;
        n5 = change / COIN_LARGE;
        if (n5 > stock5) n5 = stock5;
        return (change - n5 * COIN_LARGE) <= stock1;
    endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Acknowledge watchdog shared by the can-drop and coin-eject waits.
// expired_o fires on the TIMEOUT-th enabled cycle after a clear.
module vend_timeout_timer #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/vend_dispense.sv
// Vending dispense stage: drops the can, pays change greedily from a
// two-denomination hopper, clears the accumulator and tracks coin stock.
module vend_dispense
    import vend_pkg::*;
#(
    parameter int unsigned CHANGE_W = DEFAULT_CHANGE_W,
    parameter int unsigned STOCK_W  = 6,
    parameter int unsigned TIMEOUT  = 200,
    parameter int unsigned INIT5    = 10,
    parameter int unsigned INIT1    = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vend_req,
    input  logic [CHANGE_W-1:0] change,
    input  logic                can_sensor,
    input  logic                hopper_ack,
    input  logic                refill,
    input  logic [STOCK_W-1:0]  refill5,
    input  logic [STOCK_W-1:0]  refill1,
    output logic                can_motor,
    output logic                eject5,
    output logic                eject1,
    output logic                credit_clr,
    output logic                busy,
    output logic                exact_only,
    output logic                fault,
    output logic [STOCK_W-1:0]  stock5,
    output logic [STOCK_W-1:0]  stock1
);

    state_t               state_q, state_d;
    logic [CHANGE_W-1:0]  rem_q, rem_d;
    logic                 large_q, large_d;
    logic [STOCK_W-1:0]   stock5_q, stock5_d;
    logic [STOCK_W-1:0]   stock1_q, stock1_d;
    logic                 exact_q, exact_d;

    logic                 pay_ok;
    logic                 timer_en;
    logic                 timer_expired;
    logic [STOCK_W:0]     sum5, sum1;

    // Payability looks at the stock before any same-cycle refill lands.
    assign pay_ok   = payable(32'(change), 32'(stock5_q), 32'(stock1_q));
    assign sum5     = {1'b0, stock5_q} + {1'b0, refill5};
    assign sum1     = {1'b0, stock1_q} + {1'b0, refill1};
    assign timer_en = (state_q == ST_DROP) || (state_q == ST_WAIT_ACK);

    vend_timeout_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!timer_en),
        .en_i     (timer_en),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        large_d    = large_q;
        stock5_d   = stock5_q;
        stock1_d   = stock1_q;
        exact_d    = 1'b0;
        can_motor  = 1'b0;
        eject5     = 1'b0;
        eject1     = 1'b0;
        credit_clr = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                exact_d = vend_req && !pay_ok;
                if (refill) begin
                    stock5_d = sum5[STOCK_W] ? '1 : sum5[STOCK_W-1:0];
                    stock1_d = sum1[STOCK_W] ? '1 : sum1[STOCK_W-1:0];
                end
                if (vend_req && pay_ok) begin
                    rem_d   = change;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                can_motor = 1'b1;
                if (can_sensor) begin
                    state_d = ST_PAY;
                end else if (timer_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_PAY: begin
                if (32'(rem_q) >= COIN_LARGE && stock5_q != '0) begin
                    eject5  = 1'b1;
                    large_d = 1'b1;
                    state_d = ST_WAIT_ACK;
                end else if (rem_q != '0) begin
                    eject1  = 1'b1;
                    large_d = 1'b0;
                    state_d = ST_WAIT_ACK;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_WAIT_ACK: begin
                if (hopper_ack) begin
                    if (large_q) begin
                        rem_d = rem_q - CHANGE_W'(COIN_LARGE);
                        if (stock5_q != '0) stock5_d = stock5_q - 1'b1;
                    end else begin
                        rem_d = rem_q - CHANGE_W'(COIN_SMALL);
                        if (stock1_q != '0) stock1_d = stock1_q - 1'b1;
                    end
                    state_d = ST_PAY;
                end else if (timer_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_CLEAR: begin
                credit_clr = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (!vend_req) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            large_q  <= 1'b0;
            stock5_q <= STOCK_W'(INIT5);
            stock1_q <= STOCK_W'(INIT1);
            exact_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            large_q  <= large_d;
            stock5_q <= stock5_d;
            stock1_q <= stock1_d;
            exact_q  <= exact_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign fault      = (state_q == ST_FAULT);
    assign exact_only = exact_q;
    assign stock5     = stock5_q;
    assign stock1     = stock1_q;

endmodule

// File: tb/tb_vend_dispense.sv
// Self-checking bench for vend_dispense: a default-stock instance and one
// with no 5-unit coins, checked against a greedy change-making model.
module tb_vend_dispense;

    localparam int unsigned TO   = 200;
    localparam int unsigned SMAX = 63;

    logic       clk = 1'b0;
    logic       rst;
    logic       vend_req   [2];
    logic [3:0] change     [2];
    logic       can_sensor [2];
    logic       hopper_ack [2];
    logic       refill     [2];
    logic [5:0] refill5    [2];
    logic [5:0] refill1    [2];
    logic       can_motor  [2];
    logic       eject5     [2];
    logic       eject1     [2];
    logic       credit_clr [2];
    logic       busy       [2];
    logic       exact_only [2];
    logic       fault      [2];
    logic [5:0] stock5     [2];
    logic [5:0] stock1     [2];

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned m5 [2];
    int unsigned m1 [2];

    always #5 clk = ~clk;

    vend_dispense #(.CHANGE_W(4), .STOCK_W(6), .TIMEOUT(TO), .INIT5(10), .INIT1(20)) dut0 (
        .clk(clk), .rst(rst), .vend_req(vend_req[0]), .change(change[0]),
        .can_sensor(can_sensor[0]), .hopper_ack(hopper_ack[0]), .refill(refill[0]),
        .refill5(refill5[0]), .refill1(refill1[0]), .can_motor(can_motor[0]),
        .eject5(eject5[0]), .eject1(eject1[0]), .credit_clr(credit_clr[0]),
        .busy(busy[0]), .exact_only(exact_only[0]), .fault(fault[0]),
        .stock5(stock5[0]), .stock1(stock1[0]));

    vend_dispense #(.CHANGE_W(4), .STOCK_W(6), .TIMEOUT(TO), .INIT5(0), .INIT1(20)) dut1 (
        .clk(clk), .rst(rst), .vend_req(vend_req[1]), .change(change[1]),
        .can_sensor(can_sensor[1]), .hopper_ack(hopper_ack[1]), .refill(refill[1]),
        .refill5(refill5[1]), .refill1(refill1[1]), .can_motor(can_motor[1]),
        .eject5(eject5[1]), .eject1(eject1[1]), .credit_clr(credit_clr[1]),
        .busy(busy[1]), .exact_only(exact_only[1]), .fault(fault[1]),
        .stock5(stock5[1]), .stock1(stock1[1]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_models;
        m5[0] = 10; m1[0] = 20;
        m5[1] = 0;  m1[1] = 20;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vend_req[d] = 1'b0; change[d] = '0; can_sensor[d] = 1'b0;
            hopper_ack[d] = 1'b0; refill[d] = 1'b0; refill5[d] = '0; refill1[d] = '0;
        end
        tick;
        tick;
        rst = 1'b0;
        reset_models();
    endtask

    task automatic check_stock(input int d, input string tag);
        n_cmp++;
        if (stock5[d] !== 6'(m5[d])) begin
            n_err++;
            $display("FAIL %s stock5 d%0d got=%0d exp=%0d", tag, d, stock5[d], m5[d]);
        end
        n_cmp++;
        if (stock1[d] !== 6'(m1[d])) begin
            n_err++;
            $display("FAIL %s stock1 d%0d got=%0d exp=%0d", tag, d, stock1[d], m1[d]);
        end
    endtask

    // Raise vend_req (optionally with a refill in the same cycle) and check the
    // one-cycle response: motor on if payable from pre-refill stock, else exact_only.
    task automatic start_vend(input int d, input int unsigned chg, input bit do_ref,
                              input int unsigned r5, input int unsigned r1, output bit started);
        int unsigned n5;
        bit ok;
        n5 = chg / 5;
        if (n5 > m5[d]) n5 = m5[d];
        ok = (chg - 5 * n5) <= m1[d];
        vend_req[d] = 1'b1; change[d] = 4'(chg);
        refill[d] = do_ref; refill5[d] = 6'(r5); refill1[d] = 6'(r1);
        tick;
        refill[d] = 1'b0;
        if (do_ref) begin
            m5[d] = (m5[d] + r5 > SMAX) ? SMAX : m5[d] + r5;
            m1[d] = (m1[d] + r1 > SMAX) ? SMAX : m1[d] + r1;
        end
        n_cmp++;
        if (can_motor[d] !== ok) begin
            n_err++;
            $display("FAIL vend_start_motor d%0d chg=%0d got=%b exp=%b", d, chg, can_motor[d], ok);
        end
        n_cmp++;
        if (exact_only[d] !== !ok) begin
            n_err++;
            $display("FAIL vend_start_exact d%0d chg=%0d got=%b exp=%b", d, chg, exact_only[d], !ok);
        end
        started = ok;
    endtask

    // From DROP: wait, pulse the sensor, acknowledge each eject after a random
    // delay, and compare the coin sequence against greedy change-making.
    task automatic payout(input int d, input int unsigned chg, input int unsigned sdly,
                          input int unsigned alo, input int unsigned ahi,
                          output int unsigned clr_lat);
        int          exp_q[$];
        int          got_q[$];
        int unsigned n5, n1, lat, dly;
        bit          done;
        n5 = chg / 5;
        if (n5 > m5[d]) n5 = m5[d];
        n1 = chg - 5 * n5;
        for (int unsigned i = 0; i < n5; i++) exp_q.push_back(5);
        for (int unsigned i = 0; i < n1; i++) exp_q.push_back(1);
        clr_lat = 0;
        done = 1'b0;
        repeat (sdly) tick;
        n_cmp++;
        if (can_motor[d] !== 1'b1) begin
            n_err++;
            $display("FAIL drop_motor d%0d got=%b exp=1", d, can_motor[d]);
        end
        can_sensor[d] = 1'b1;
        tick;
        can_sensor[d] = 1'b0;
        lat = 1;
        for (int c = 0; c < 400 && !done; c++) begin
            if (credit_clr[d]) begin
                done = 1'b1;
                clr_lat = lat;
            end else if (eject5[d] || eject1[d]) begin
                n_cmp++;
                if (eject5[d] && eject1[d]) begin
                    n_err++;
                    $display("FAIL eject_both d%0d got=11 exp=one-hot", d);
                end
                got_q.push_back(eject5[d] ? 5 : 1);
                dly = $urandom_range(ahi, alo);
                tick;
                repeat (dly - 1) tick;
                hopper_ack[d] = 1'b1;
                tick;
                hopper_ack[d] = 1'b0;
                lat += dly + 1;
            end else begin
                tick;
                lat++;
            end
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL payout_budget d%0d chg=%0d got=no-credit_clr exp=credit_clr", d, chg);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL coin_count d%0d chg=%0d got=%0d exp=%0d", d, chg, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] != exp_q[i]) begin
                n_err++;
                $display("FAIL coin_order d%0d idx=%0d got=%0d exp=%0d", d, i, got_q[i], exp_q[i]);
            end
        end
        m5[d] -= n5;
        m1[d] -= n1;
        tick;
        n_cmp++;
        if ({credit_clr[d], busy[d]} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_state d%0d got clr/busy=%b%b exp=01", d, credit_clr[d], busy[d]);
        end
        vend_req[d] = 1'b0;
        tick;
        n_cmp++;
        if (busy[d] !== 1'b0) begin
            n_err++;
            $display("FAIL return_idle d%0d got=%b exp=0", d, busy[d]);
        end
        check_stock(d, "after_payout");
    endtask

    task automatic test_reset;
        apply_reset();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({can_motor[d], eject5[d], eject1[d], credit_clr[d], busy[d], exact_only[d], fault[d]} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_outputs d%0d got=%b exp=0000000", d,
                         {can_motor[d], eject5[d], eject1[d], credit_clr[d], busy[d], exact_only[d], fault[d]});
            end
            check_stock(d, "reset");
        end
    endtask

    task automatic test_zero_change;
        bit st;
        int unsigned lat;
        start_vend(0, 0, 1'b0, 0, 0, st);
        payout(0, 0, 3, 1, 1, lat);
        n_cmp++;
        if (lat != 2) begin
            n_err++;
            $display("FAIL zero_change_clr_latency got=%0d exp=2", lat);
        end
    endtask

    task automatic test_change7;
        bit st;
        int unsigned lat;
        start_vend(0, 7, 1'b0, 0, 0, st);
        payout(0, 7, 2, 2, 2, lat);
    endtask

    task automatic test_no_fives;
        bit st;
        int unsigned lat;
        start_vend(1, 7, 1'b0, 0, 0, st);
        payout(1, 7, 1, 1, 2, lat);
        start_vend(1, 6, 1'b0, 0, 0, st);
        payout(1, 6, 0, 1, 1, lat);
        start_vend(1, 6, 1'b0, 0, 0, st);
        payout(1, 6, 0, 1, 1, lat);
    endtask

    task automatic test_exact_only;
        bit st;
        int unsigned lat;
        start_vend(1, 7, 1'b0, 0, 0, st);
        tick;
        n_cmp++;
        if ({exact_only[1], can_motor[1]} !== 2'b10) begin
            n_err++;
            $display("FAIL exact_hold got exact/motor=%b%b exp=10", exact_only[1], can_motor[1]);
        end
        refill[1] = 1'b1; refill5[1] = '0; refill1[1] = 6'd10;
        tick;
        refill[1] = 1'b0;
        m1[1] += 10;
        n_cmp++;
        if ({exact_only[1], can_motor[1]} !== 2'b10) begin
            n_err++;
            $display("FAIL exact_refill_cycle got exact/motor=%b%b exp=10", exact_only[1], can_motor[1]);
        end
        check_stock(1, "refill_idle");
        tick;
        n_cmp++;
        if ({exact_only[1], can_motor[1]} !== 2'b01) begin
            n_err++;
            $display("FAIL exact_release got exact/motor=%b%b exp=01", exact_only[1], can_motor[1]);
        end
        payout(1, 7, 1, 1, 3, lat);
    endtask

    task automatic test_random;
        bit st, rf;
        int unsigned chg, lat, r5, r1;
        for (int it = 0; it < 14; it++) begin
            chg = $urandom_range(15, 0);
            rf  = ($urandom_range(3, 0) == 0);
            r5  = $urandom_range(20, 0);
            r1  = $urandom_range(20, 0);
            start_vend(0, chg, rf, r5, r1, st);
            if (st) begin
                payout(0, chg, $urandom_range(5, 0), 1, 4, lat);
            end else begin
                vend_req[0] = 1'b0;
                tick;
                n_cmp++;
                if (exact_only[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL exact_clear got=%b exp=0", exact_only[0]);
                end
                r5 = $urandom_range(63, 0);
                r1 = $urandom_range(63, 0);
                refill[0] = 1'b1; refill5[0] = 6'(r5); refill1[0] = 6'(r1);
                tick;
                refill[0] = 1'b0;
                m5[0] = (m5[0] + r5 > SMAX) ? SMAX : m5[0] + r5;
                m1[0] = (m1[0] + r1 > SMAX) ? SMAX : m1[0] + r1;
                check_stock(0, "refill_sat");
            end
        end
    endtask

    task automatic test_drop_timeout;
        bit st, clr_seen;
        apply_reset();
        clr_seen = 1'b0;
        start_vend(0, 3, 1'b0, 0, 0, st);
        repeat (TO - 1) begin
            tick;
            clr_seen |= credit_clr[0];
        end
        n_cmp++;
        if ({fault[0], can_motor[0]} !== 2'b01) begin
            n_err++;
            $display("FAIL drop_pre_timeout got fault/motor=%b%b exp=01", fault[0], can_motor[0]);
        end
        tick;
        n_cmp++;
        if ({fault[0], can_motor[0], busy[0]} !== 3'b101) begin
            n_err++;
            $display("FAIL drop_timeout got fault/motor/busy=%b%b%b exp=101", fault[0], can_motor[0], busy[0]);
        end
        vend_req[0] = 1'b0;
        tick;
        vend_req[0] = 1'b1; change[0] = 4'd0;
        hopper_ack[0] = 1'b1;
        tick;
        hopper_ack[0] = 1'b0;
        repeat (3) begin
            tick;
            clr_seen |= credit_clr[0];
        end
        n_cmp++;
        if ({fault[0], can_motor[0], eject5[0], eject1[0], clr_seen} !== 5'b10000) begin
            n_err++;
            $display("FAIL fault_sticky got fault/motor/e5/e1/clr=%b%b%b%b%b exp=10000",
                     fault[0], can_motor[0], eject5[0], eject1[0], clr_seen);
        end
        check_stock(0, "fault");
        apply_reset();
        n_cmp++;
        if (fault[0] !== 1'b0) begin
            n_err++;
            $display("FAIL fault_cleared got=%b exp=0", fault[0]);
        end
    endtask

    task automatic test_ack_timeout;
        bit st;
        start_vend(0, 1, 1'b0, 0, 0, st);
        can_sensor[0] = 1'b1;
        tick;
        can_sensor[0] = 1'b0;
        n_cmp++;
        if ({eject5[0], eject1[0]} !== 2'b01) begin
            n_err++;
            $display("FAIL ack_to_eject got e5/e1=%b%b exp=01", eject5[0], eject1[0]);
        end
        tick;
        repeat (TO - 1) tick;
        n_cmp++;
        if ({fault[0], busy[0]} !== 2'b01) begin
            n_err++;
            $display("FAIL ack_pre_timeout got fault/busy=%b%b exp=01", fault[0], busy[0]);
        end
        tick;
        n_cmp++;
        if (fault[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ack_timeout got=%b exp=1", fault[0]);
        end
        hopper_ack[0] = 1'b1;
        tick;
        hopper_ack[0] = 1'b0;
        tick;
        check_stock(0, "ack_fault");
        apply_reset();
    endtask

    task automatic test_reset_mid;
        bit st;
        int unsigned lat;
        start_vend(0, 7, 1'b0, 0, 0, st);
        payout(0, 7, 0, 1, 2, lat);
        start_vend(0, 6, 1'b0, 0, 0, st);
        refill[0] = 1'b1; refill5[0] = 6'd5; refill1[0] = 6'd5;
        tick;
        refill[0] = 1'b0;
        check_stock(0, "refill_busy");
        can_sensor[0] = 1'b1;
        tick;
        can_sensor[0] = 1'b0;
        n_cmp++;
        if (eject5[0] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_eject5 got=%b exp=1", eject5[0]);
        end
        tick;
        vend_req[0] = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        reset_models();
        n_cmp++;
        if ({can_motor[0], eject5[0], eject1[0], credit_clr[0], busy[0], exact_only[0], fault[0]} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_mid_outputs got=%b exp=0000000",
                     {can_motor[0], eject5[0], eject1[0], credit_clr[0], busy[0], exact_only[0], fault[0]});
        end
        check_stock(0, "reset_mid");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_change();
        test_change7();
        test_no_fives();
        test_exact_only();
        test_random();
        test_drop_timeout();
        test_ack_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
